// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-path branch unit: opcode encoding,
// absolute jump table and the offset sign-extension helper.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NOP  = 3'd0,
    BR_BEQZ = 3'd1,
    BR_BNEZ = 3'd2,
    BR_JMP  = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5,
    BR_DONE = 3'd6
  } br_op_t;

  localparam int LUT_W = 16;

  // Absolute entry points for JMP/CALL, indexed by imm[3:0].
  localparam logic [LUT_W-1:0] JMP_LUT [16] = '{
    16'h0100, 16'h0120, 16'h0140, 16'h0160,
    16'h0200, 16'h0220, 16'h0240, 16'h0260,
    16'h0300, 16'h0320, 16'h0340, 16'h0360,
    16'h0400, 16'h0420, 16'h0440, 16'h0460
  };

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/branch_unit_ret_stack.sv
// Return-address LIFO. sp counts occupied entries (0..DEPTH); full/empty and
// top are judged on the sp held at the start of the cycle.
module ret_stack #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic            full,
  output logic            empty,
  output logic [PC_W-1:0] top
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [AW-1:0]   top_idx;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = AW'(sp_q - SP_W'(1));
  assign top     = mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[sp_q[AW-1:0]] = din;
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch decode for the fetch path: combinational jump decisions into the PC
// register, CALL/RET stack handling, program-completion counting.
module branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init,
  input  logic [PC_W-1:0] pc,
  input  br_op_t          op,
  input  logic [7:0]      imm,
  input  logic            zero,
  output logic            jump_rel,
  output logic            jump_abs,
  output logic [PC_W-1:0] target,
  output logic            done,
  output logic [1:0]      prog_id,
  output logic            stack_err
);

  logic            rel_raw, abs_raw;
  logic [PC_W-1:0] tgt_raw;
  logic            push, pop, err_set, done_set;
  logic            st_full, st_empty;
  logic [PC_W-1:0] st_top;
  logic            done_q, done_d;
  logic [1:0]      prog_id_q, prog_id_d;
  logic            stack_err_q, stack_err_d;

  ret_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc + PC_W'(1)),
    .full  (st_full),
    .empty (st_empty),
    .top   (st_top)
  );

  always_comb begin
    rel_raw  = 1'b0;
    abs_raw  = 1'b0;
    tgt_raw  = '0;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    if (!init) begin
      unique case (op)
        BR_BEQZ: if (zero) begin
          rel_raw = 1'b1;
          tgt_raw = PC_W'(sext8(imm));
        end
        BR_BNEZ: if (!zero) begin
          rel_raw = 1'b1;
          tgt_raw = PC_W'(sext8(imm));
        end
        BR_JMP: begin
          abs_raw = 1'b1;
          tgt_raw = PC_W'(JMP_LUT[imm[3:0]]);
        end
        BR_CALL: if (!st_full) begin
          abs_raw = 1'b1;
          tgt_raw = PC_W'(JMP_LUT[imm[3:0]]);
          push    = 1'b1;
        end else begin
          err_set = 1'b1;
        end
        BR_RET: if (!st_empty) begin
          abs_raw = 1'b1;
          tgt_raw = st_top;
          pop     = 1'b1;
        end else begin
          err_set = 1'b1;
        end
        BR_DONE: done_set = 1'b1;
        default: ;
      endcase
    end
  end

  // Jump outputs are combinational, so hold them quiet while reset is asserted.
  assign jump_rel = rel_raw & rst_n;
  assign jump_abs = abs_raw & rst_n;
  assign target   = rst_n ? tgt_raw : '0;

  always_comb begin
    done_d      = done_set;
    prog_id_d   = (done_set && prog_id_q != 2'd3) ? prog_id_q + 2'd1 : prog_id_q;
    stack_err_d = stack_err_q | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      prog_id_q   <= 2'd0;
      stack_err_q <= 1'b0;
    end else begin
      done_q      <= done_d;
      prog_id_q   <= prog_id_d;
      stack_err_q <= stack_err_d;
    end
  end

  assign done      = done_q;
  assign prog_id   = prog_id_q;
  assign stack_err = stack_err_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Control-flow generator for the fetch path: decodes a 3-bit branch opcode from the current instruction and drives `jump_rel`, `jump_abs` and `target` into the program counter. It also keeps a small return-address stack for CALL/RET and counts DONE markers so the bench knows which of the three concatenated programs is running. It sits between instruction decode and the PC register. Decisions are combinational in the cycle the PC register samples them; all internal state updates on the same clock edge.

## Interface
Parameters:
- `PC_W`, 16, width of PC and target
- `DEPTH`, 4, return-stack entries (power of 2, ≥2)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `init`  in  1  bench stall; while 1, no state changes and both jump outputs are 0
- `pc`  in  PC_W  current PC value
- `op`  in  3  branch opcode (`branch_pkg::br_op_t`)
- `imm`  in  8  signed offset (BEQZ/BNEZ) or LUT index in `imm[3:0]` (JMP/CALL)
- `zero`  in  1  ALU zero flag for the current instruction
- `jump_rel`  out  1  PC ← PC + target
- `jump_abs`  out  1  PC ← target
- `target`  out  PC_W  jump amount or address; 0 when no jump is asserted
- `done`  out  1  one-cycle pulse, registered
- `prog_id`  out  2  completed-program count, saturates at 3
- `stack_err`  out  1  sticky overflow/underflow flag

## Operation
Opcodes: NOP=0, BEQZ=1, BNEZ=2, JMP=3, CALL=4, RET=5, DONE=6; 7 behaves as NOP.
- BEQZ: if `zero`=1, `jump_rel`=1 and `target`=sign-extended `imm`.
- BNEZ: same as BEQZ, but taken when `zero`=0.
- JMP: `jump_abs`=1, `target`=`JMP_LUT[imm[3:0]]`.
- CALL: if the stack is not full, `jump_abs`=1, `target`=LUT entry, push `pc+1` (mod 2^PC_W). If the stack is full, no jump, no push, `stack_err`←1.
- RET: if the stack is not empty, `jump_abs`=1, `target`=top, pop. If the stack is empty, no jump, `stack_err`←1.
- DONE: no jump, so the PC falls through into the next program. `done` pulses the following cycle and `prog_id` increments (holds at 3).
- `jump_rel` and `jump_abs` are never both 1.
- Relative arithmetic wraps mod 2^PC_W. The PC register performs the add; this block only sign-extends.
- `init`=1 overrides everything: outputs are forced to no-jump, sp, stack, `prog_id` and `stack_err` hold, and `done` is 0 in the next cycle.

## Timing
- Reset values: `jump_rel`=0, `jump_abs`=0, `target`=0, `done`=0, `prog_id`=0, `stack_err`=0, sp=0, stack entries 0.
- Jump outputs are combinational from `op`, `imm`, `zero`, `pc` and the stack top, with zero latency. They are sampled by the PC register at the same edge that pushes or pops.
- Push and pop take effect at the edge. A RET in the cycle immediately after a CALL returns the just-pushed `pc+1`.
- `done` is high exactly one cycle, the cycle after DONE is presented with `init`=0. Back-to-back DONEs produce back-to-back pulses.
- `rst_n` falling mid-operation clears all state asynchronously. Jump outputs go to 0 while reset is held.
- Full/empty is judged on sp at the start of the cycle. sp ranges 0..DEPTH, so it needs log2(DEPTH)+1 bits.

## Structure
- `branch_pkg`: `br_op_t` enum, `JMP_LUT` constant array (16 × PC_W), and a `sext8` function.
- Sub-module `ret_stack`: a LIFO with push/pop/full/empty/top, parameterised by DEPTH and PC_W, using the same async active-low reset.
- The top level holds the opcode decode, the `done` and `prog_id` registers, and the sticky `stack_err`.

## Test plan
- Reset then NOP with `pc`=0x0010 → `jump_rel`=`jump_abs`=0, `target`=0, `prog_id`=0.
- BEQZ with `imm`=0xFC, `zero`=1 → `jump_rel`=1, `target`=0xFFFC. The same op with `zero`=0 → no jump.
- CALL with `imm`=2 at `pc`=0x0020, then RET → the first cycle gives `jump_abs`=1, `target`=`JMP_LUT[2]`. The next cycle gives `jump_abs`=1, `target`=0x0021.
- Five CALLs with DEPTH=4 → the first four jump, the fifth has no jump and `stack_err`=1 and stays 1. Four RETs pop in LIFO order, and a fifth RET does not jump.
- Four DONEs with `init`=1 during the second → three `done` pulses, `prog_id` goes 1, 2, 3 and holds at 3.
- `rst_n` pulsed low after two pushes → sp=0, `stack_err`=0, and a following RET raises `stack_err` with no jump.
